seq_dffr_pipe: RTL and testbench

SEQ_DFFR_PIPE -- requirements
Module: seq_dffr_pipe

---
 rtl/seq_dffr_pipe.sv | 154 +++++++++++++++
 tb/tb_seq_dffr_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_dffr_pipe.sv
// ----------------------------------------------------------------------------
// seq_dffr_pipe
//   Elastic register pipeline of DEPTH stages with valid/ready handshakes at
//   both ends. Each stage owns a valid bit and a WIDTH-bit data register.
//   A stage advances whenever it is "free": empty, or about to be emptied by
//   the stage downstream (or by the consumer, for the last stage). This gives
//   one item per cycle when unstalled, DEPTH-cycle latency, and bubble
//   collapse when the output stalls.
//
//   Optional feature macro: SEQ_DFFR_PIPE_CLEAR_EN
//     When defined, adds input 'clear'. A clear flushes every stage back to
//     RESET_VAL and blocks input for that cycle. An output handshake in the
//     same cycle still completes.
//
// Parameters
//   WIDTH      data width in bits (>=1)
//   DEPTH      number of register stages (>=1)
//   RESET_VAL  value loaded into every data register on reset/clear
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   clear     synchronous flush (only with SEQ_DFFR_PIPE_CLEAR_EN)
//   in_val    input item valid
//   in_rdy    pipeline can accept an item this cycle (combinational on out_rdy)
//   in_data   input payload
//   out_val   last stage holds a valid item
//   out_rdy   consumer takes the item this cycle
//   out_data  last-stage payload (registered)
//   count     number of valid stages
// ----------------------------------------------------------------------------

// One pipeline stage: valid bit plus data register. The data register only
// moves when a valid item is loaded, so an empty stage keeps its last value.
module seq_dffr_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);
    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!reset || i_clr) begin
            r_vld  <= 1'b0;
            r_data <= RESET_VAL;
        end else if (i_load) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
endmodule

module seq_dffr_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
`ifdef SEQ_DFFR_PIPE_CLEAR_EN
    input  logic                       clear,
`endif
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            w_vld_pipe;   // registered valid per stage
    logic [DEPTH-1:0][WIDTH-1:0] w_data_pipe;  // registered data per stage
    logic [DEPTH-1:0]            w_free;       // stage may load this edge
    logic [DEPTH-1:0]            w_up_vld;     // valid presented to each stage
    logic [DEPTH-1:0][WIDTH-1:0] w_up_data;    // data presented to each stage
    logic [CW-1:0]               w_cnt;
    logic                        w_clr;

`ifdef SEQ_DFFR_PIPE_CLEAR_EN
    assign w_clr = clear;
`else
    assign w_clr = 1'b0;
`endif

    // Freeness ripples from the output back to the input: a stage is free if
    // it is empty or everything downstream of it is moving. This is the path
    // that makes in_rdy combinational on out_rdy.
    always_comb begin
        w_free            = '0;
        w_free[DEPTH-1]   = !w_vld_pipe[DEPTH-1] || out_rdy;
        for (int i = DEPTH-2; i >= 0; i--) begin
            w_free[i] = !w_vld_pipe[i] || w_free[i+1];
        end
    end

    // Input is refused during a clear so a flushed cycle cannot sneak an item in.
    assign in_rdy = w_free[0] && !w_clr;

    // Each stage takes from its upstream neighbour; stage 0 takes from the port.
    always_comb begin
        w_up_vld     = '0;
        w_up_data    = '0;
        w_up_vld[0]  = in_val && in_rdy;
        w_up_data[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_up_vld[i]  = w_vld_pipe[i-1];
            w_up_data[i] = w_data_pipe[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        seq_dffr_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .i_clr  (w_clr),
            .i_load (w_free[g]),
            .i_vld  (w_up_vld[g]),
            .i_data (w_up_data[g]),
            .o_vld  (w_vld_pipe[g]),
            .o_data (w_data_pipe[g])
        );
    end

    // Occupancy is the population of the valid bits.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt = w_cnt + CW'(w_vld_pipe[i]);
        end
    end

    assign count    = w_cnt;
    assign out_val  = w_vld_pipe[DEPTH-1];
    assign out_data = w_data_pipe[DEPTH-1];
endmodule

// File: tb/tb_seq_dffr_pipe.sv
// ----------------------------------------------------------------------------
// tb_seq_dffr_pipe
//   Scoreboard bench for seq_dffr_pipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
//   Accepted items are queued with the edge at which they entered. The
//   reference model treats the pipe as an ordered queue: the oldest item is
//   visible at the output once it has been inside for DEPTH-1 further edges,
//   input is ready whenever fewer than DEPTH items are held or the consumer
//   is taking one, and an idle output shows the last item that left (or
//   RESET_VAL after reset/clear). Build with +define+SEQ_DFFR_PIPE_CLEAR_EN
//   to exercise the clear port.
// ----------------------------------------------------------------------------
module tb_seq_dffr_pipe;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
`ifdef SEQ_DFFR_PIPE_CLEAR_EN
    logic       clear;
`endif
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_data;
    logic [1:0] count;

    int total = 0;
    int bad   = 0;

    seq_dffr_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef SEQ_DFFR_PIPE_CLEAR_EN
        .clear    (clear),
`endif
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    logic [7:0] q_d[$];     // items held, oldest first
    int         q_t[$];     // edge index at which each item entered
    int         edge_cnt = 0;
    logic [7:0] last_out = RV;
    bit         armed    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor_step();
        logic       clr_now;
        logic       exp_val;
        logic       exp_rdy;
        logic [7:0] head;
        clr_now = 1'b0;
`ifdef SEQ_DFFR_PIPE_CLEAR_EN
        clr_now = clear && reset;
`endif
        exp_rdy = !clr_now && ((q_d.size() < DEPTH) || out_rdy);
        exp_val = (q_d.size() > 0) && ((edge_cnt - q_t[0]) >= DEPTH-1);
        if (armed) begin
            chk("out_val", 32'(out_val), 32'(exp_val));
            chk("count",   32'(count),   32'(q_d.size()));
            chk("in_rdy",  32'(in_rdy),  32'(exp_rdy));
            if (!exp_val) chk("idle_data", 32'(out_data), 32'(last_out));
        end
        if (!reset) begin
            q_d.delete();
            q_t.delete();
            last_out = RV;
            armed    = 1'b1;
        end else if (armed) begin
            if (exp_val && out_rdy) begin
                head = q_d.pop_front();
                void'(q_t.pop_front());
                chk("sb_data", 32'(out_data), 32'(head));
                last_out = head;
            end
            if (clr_now) begin
                q_d.delete();
                q_t.delete();
                last_out = RV;
            end else if (in_val && exp_rdy) begin
                q_d.push_back(in_data);
                q_t.push_back(edge_cnt + 1);
            end
        end
        edge_cnt++;
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bit acc = 1'b0;
        int n   = 0;
        in_val  = 1'b1;
        in_data = d;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_rdy;
            tick();
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: item %0h not accepted in %0d cycles", d, n);
        end
        in_val = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
`ifdef SEQ_DFFR_PIPE_CLEAR_EN
        clear   = 1'b0;
`endif
        in_val  = 1'b1;
        in_data = 8'($urandom);
        out_rdy = 1'b1;
        // reset held with in_val asserted
        repeat (3) tick();
        reset  = 1'b1;
        in_val = 1'b0;

        // single-item latency, then a back-to-back stream
        out_rdy = 1'b1;
        send(8'h11);
        repeat (4) tick();
        for (int i = 1; i <= 10; i++) send(8'(i));
        repeat (4) tick();

        // backpressure: three fit, fourth waits for the consumer
        out_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
            end
            begin
                repeat (6) tick();
                out_rdy = 1'b1;
            end
        join
        repeat (4) tick();

        // full pipe with consumer ready passes one in / one out per cycle
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h30 + 8'(i));
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h40 + 8'(i));
        repeat (4) tick();

        // bubble collapse under a stalled output
        out_rdy = 1'b0;
        send(8'h55);
        repeat (4) tick();
        out_rdy = 1'b1;
        repeat (2) tick();

`ifdef SEQ_DFFR_PIPE_CLEAR_EN
        // flush a full pipe while an item is offered
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h60 + 8'(i));
        clear   = 1'b1;
        in_val  = 1'b1;
        in_data = 8'h77;
        tick();
        clear  = 1'b0;
        in_val = 1'b0;
        tick();
        out_rdy = 1'b1;
        repeat (3) tick();
`endif

        // randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            in_val  = ($urandom_range(0, 2) != 0);
            in_data = 8'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 60) != 0);
`ifdef SEQ_DFFR_PIPE_CLEAR_EN
            clear   = ($urandom_range(0, 40) == 0);
`endif
            tick();
        end
        reset   = 1'b1;
`ifdef SEQ_DFFR_PIPE_CLEAR_EN
        clear   = 1'b0;
`endif
        in_val  = 1'b0;
        out_rdy = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
